// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-port RAM core: read status bit positions and status type.
package meduram_pkg;

    localparam int unsigned RDST_COLL = 0;
    localparam int unsigned RDST_UNWR = 1;

    typedef logic [1:0] rd_status_t;

endpackage

// File: rtl/meduram_rr_arbiter.sv
// Round-robin grant for one same-address write group: first requester at or after the
// one-hot pointer wins. Purely combinational; the pointer is owned by the core.
module meduram_rr_arbiter
    import meduram_pkg::*;
#(
    parameter int unsigned NB_WR = 2
) (
    input  logic [NB_WR-1:0] req_i,
    input  logic [NB_WR-1:0] ptr_i,
    output logic [NB_WR-1:0] gnt_o
);

    localparam logic [NB_WR-1:0] One = NB_WR'(1);

    logic [NB_WR-1:0] mask;
    logic [NB_WR-1:0] req_hi;
    logic [NB_WR-1:0] pick;

    // Bits at or above the pointer; wrap to the full request vector if none are set there.
    always_comb begin
        mask   = ~(ptr_i - One);
        req_hi = req_i & mask;
        pick   = (req_hi != '0) ? req_hi : req_i;
        gnt_o  = pick & (~pick + One);
    end

endmodule

// File: rtl/meduram_mp_core.sv
// NB_WR-writer / NB_RD-reader RAM core with round-robin same-address write arbitration.
// Define MEDURAM_WR_BYPASS_EN to forward a committing write's data to same-cycle readers.
module meduram_mp_core
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NB_WR      = 2,
    parameter int unsigned NB_RD      = 2
) (
    input  logic                        aclk_i,
    input  logic                        srst_i,
    input  logic [NB_WR-1:0]            wren_i,
    input  logic [NB_WR*ADDR_WIDTH-1:0] wraddr_i,
    input  logic [NB_WR*DATA_WIDTH-1:0] wrdata_i,
    output logic [NB_WR-1:0]            wrdone_o,
    output logic [NB_WR-1:0]            wrcoll_o,
    input  logic [NB_RD-1:0]            rden_i,
    input  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr_i,
    output logic [NB_RD-1:0]            rdvalid_o,
    output logic [NB_RD*DATA_WIDTH-1:0] rddata_o,
    output logic [NB_RD*2-1:0]          rdstatus_o
);

    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [NB_WR-1:0]    One    = NB_WR'(1);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_DEPTH-1:0]  valid_q;
    logic [NB_WR-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NB_WR-1:0]            wrdone_q, wrcoll_q;
    logic [NB_RD-1:0]            rdvalid_q;
    logic [NB_RD*DATA_WIDTH-1:0] rddata_q, rddata_d;
    logic [NB_RD*2-1:0]          rdstatus_q, rdstatus_d;

    logic [ADDR_WIDTH-1:0] wa [NB_WR];
    logic [DATA_WIDTH-1:0] wd [NB_WR];
    logic [ADDR_WIDTH-1:0] ra [NB_RD];
    logic [NB_WR-1:0]      wr_ok;
    logic [NB_WR-1:0]      grp_req [NB_WR];
    logic [NB_WR-1:0]      grp_gnt [NB_WR];
    logic [NB_WR-1:0]      commit, lost;
    logic                  rr_adv;
    int unsigned           win_idx;
    rd_status_t            st [NB_RD];
    logic [NB_RD-1:0]      rd_hit;
`ifdef MEDURAM_WR_BYPASS_EN
    logic [DATA_WIDTH-1:0] rd_byp [NB_RD];
`endif

    // Requests are qualified here so srst and out-of-range writes never reach arbitration.
    always_comb begin
        for (int unsigned i = 0; i < NB_WR; i++) begin
            wa[i]    = wraddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            wd[i]    = wrdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            wr_ok[i] = !srst_i && wren_i[i] && ({1'b0, wa[i]} < DepthW);
        end
        for (int unsigned i = 0; i < NB_WR; i++) begin
            grp_req[i] = '0;
            for (int unsigned j = 0; j < NB_WR; j++) begin
                grp_req[i][j] = wr_ok[i] && wr_ok[j] && (wa[j] == wa[i]);
            end
        end
        for (int unsigned r = 0; r < NB_RD; r++) begin
            ra[r] = rdaddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    for (genvar i = 0; i < NB_WR; i++) begin : g_arb
        meduram_rr_arbiter #(
            .NB_WR(NB_WR)
        ) u_arb (
            .req_i(grp_req[i]),
            .ptr_i(rr_ptr_q),
            .gnt_o(grp_gnt[i])
        );
    end

    // Pointer moves only when a group had more than one requester, past the highest such winner.
    always_comb begin
        rr_adv  = 1'b0;
        win_idx = 0;
        for (int unsigned i = 0; i < NB_WR; i++) begin
            commit[i] = grp_gnt[i][i];
            lost[i]   = wr_ok[i] && !grp_gnt[i][i];
            if (commit[i] && ((grp_req[i] & ~(One << i)) != '0)) begin
                rr_adv  = 1'b1;
                win_idx = i;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (rr_adv) begin
            rr_ptr_d = (win_idx == NB_WR - 1) ? One : (One << (win_idx + 1));
        end
    end

    always_comb begin
        rddata_d   = '0;
        rdstatus_d = '0;
        for (int unsigned r = 0; r < NB_RD; r++) begin
            st[r]     = '0;
            rd_hit[r] = 1'b0;
`ifdef MEDURAM_WR_BYPASS_EN
            rd_byp[r] = '0;
`endif
            if (rden_i[r]) begin
                if ({1'b0, ra[r]} < DepthW) begin
                    for (int unsigned j = 0; j < NB_WR; j++) begin
                        if (commit[j] && (wa[j] == ra[r])) begin
                            rd_hit[r] = 1'b1;
`ifdef MEDURAM_WR_BYPASS_EN
                            rd_byp[r] = wd[j];
`endif
                        end
                    end
                    rddata_d[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[r]];
                    st[r][RDST_UNWR] = !valid_q[ra[r]];
                    st[r][RDST_COLL] = rd_hit[r];
`ifdef MEDURAM_WR_BYPASS_EN
                    if (rd_hit[r]) begin
                        rddata_d[r*DATA_WIDTH +: DATA_WIDTH] = rd_byp[r];
                        st[r][RDST_UNWR] = 1'b0;
                    end
`endif
                end else begin
                    st[r][RDST_UNWR] = 1'b1;
                end
            end
            rdstatus_d[r*2 +: 2] = st[r];
        end
    end

    always_ff @(posedge aclk_i) begin
        if (srst_i) begin
            valid_q    <= '0;
            rr_ptr_q   <= One;
            wrdone_q   <= '0;
            wrcoll_q   <= '0;
            rdvalid_q  <= '0;
            rddata_q   <= '0;
            rdstatus_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_WR; i++) begin
                if (commit[i]) valid_q[wa[i]] <= 1'b1;
            end
            rr_ptr_q   <= rr_ptr_d;
            wrdone_q   <= commit;
            wrcoll_q   <= lost;
            rdvalid_q  <= rden_i;
            rddata_q   <= rddata_d;
            rdstatus_q <= rdstatus_d;
        end
    end

    // Storage array carries no reset; commit is already gated by srst.
    always_ff @(posedge aclk_i) begin
        for (int unsigned i = 0; i < NB_WR; i++) begin
            if (commit[i]) mem_q[wa[i]] <= wd[i];
        end
    end

    assign wrdone_o   = wrdone_q;
    assign wrcoll_o   = wrcoll_q;
    assign rdvalid_o  = rdvalid_q;
    assign rddata_o   = rddata_q;
    assign rdstatus_o = rdstatus_q;

endmodule

// File: tb/tb_meduram_mp_core.sv
// Bench for meduram_mp_core: directed scenarios plus random traffic against a behavioural model.
// Honours MEDURAM_WR_BYPASS_EN for same-cycle read/write expectations.
module tb_meduram_mp_core;

    localparam int AW = 3, DEPTH = 6, DW = 8, NW = 3, NR = 2;

    logic             clk = 1'b0;
    logic             srst;
    logic [NW-1:0]    wren;
    logic [NW*AW-1:0] wraddr;
    logic [NW*DW-1:0] wrdata;
    logic [NW-1:0]    wrdone, wrcoll;
    logic [NR-1:0]    rden;
    logic [NR*AW-1:0] rdaddr;
    logic [NR-1:0]    rdvalid;
    logic [NR*DW-1:0] rddata;
    logic [NR*2-1:0]  rdstatus;

    int n_vec = 0, n_err = 0;

    logic [DW-1:0] m_mem [8];
    bit            m_val [8];
    int            m_rr;
    logic [NW-1:0] e_wrdone, e_wrcoll;
    logic [NR-1:0] e_rdvalid;
    logic [DW-1:0] e_rddata [NR];
    logic [1:0]    e_rdst [NR];
    bit            e_chk [NR];

`ifdef MEDURAM_WR_BYPASS_EN
    localparam logic [7:0] CollData = 8'h44;
`else
    localparam logic [7:0] CollData = 8'h33;
`endif

    always #5 clk = ~clk;

    meduram_mp_core #(
        .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .NB_WR(NW), .NB_RD(NR)
    ) dut (
        .aclk_i(clk), .srst_i(srst),
        .wren_i(wren), .wraddr_i(wraddr), .wrdata_i(wrdata),
        .wrdone_o(wrdone), .wrcoll_o(wrcoll),
        .rden_i(rden), .rdaddr_i(rdaddr),
        .rdvalid_o(rdvalid), .rddata_o(rddata), .rdstatus_o(rdstatus)
    );

    task automatic clr();
        wren = '0; wraddr = '0; wrdata = '0; rden = '0; rdaddr = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        wren[p] = 1'b1;
        wraddr[p*AW +: AW] = AW'(a);
        wrdata[p*DW +: DW] = d;
    endtask

    task automatic rd(input int r, input int a);
        rden[r] = 1'b1;
        rdaddr[r*AW +: AW] = AW'(a);
    endtask

    // Group requests by address, pick winners by round-robin order, then apply commits.
    task automatic model_step();
        int n, win, hi, p, a;
        bit wcom [8];
        logic [DW-1:0] wdat [8];
        e_wrdone = '0; e_wrcoll = '0; e_rdvalid = '0;
        for (int r = 0; r < NR; r++) begin
            e_rddata[r] = '0; e_rdst[r] = 2'b00; e_chk[r] = 1'b0;
        end
        if (srst) begin
            for (int k = 0; k < 8; k++) m_val[k] = 1'b0;
            m_rr = 0;
            return;
        end
        hi = -1;
        for (int ad = 0; ad < 8; ad++) begin
            wcom[ad] = 1'b0; wdat[ad] = '0;
            if (ad >= DEPTH) continue;
            n = 0; win = -1;
            for (int q = 0; q < NW; q++) if (wren[q] && int'(wraddr[q*AW +: AW]) == ad) n++;
            if (n == 0) continue;
            for (int k = 0; k < NW; k++) begin
                p = (m_rr + k) % NW;
                if (win < 0 && wren[p] && int'(wraddr[p*AW +: AW]) == ad) win = p;
            end
            for (int q = 0; q < NW; q++) begin
                if (wren[q] && int'(wraddr[q*AW +: AW]) == ad) begin
                    if (q == win) e_wrdone[q] = 1'b1;
                    else          e_wrcoll[q] = 1'b1;
                end
            end
            wcom[ad] = 1'b1;
            wdat[ad] = wrdata[win*DW +: DW];
            if (n > 1 && win > hi) hi = win;
        end
        for (int r = 0; r < NR; r++) begin
            if (!rden[r]) continue;
            e_rdvalid[r] = 1'b1;
            a = int'(rdaddr[r*AW +: AW]);
            if (a >= DEPTH) begin
                e_rdst[r] = 2'b10; e_chk[r] = 1'b1;
            end else if (wcom[a]) begin
`ifdef MEDURAM_WR_BYPASS_EN
                e_rddata[r] = wdat[a]; e_rdst[r] = 2'b01; e_chk[r] = 1'b1;
`else
                e_rddata[r] = m_mem[a]; e_rdst[r] = {!m_val[a], 1'b1}; e_chk[r] = m_val[a];
`endif
            end else begin
                e_rddata[r] = m_mem[a]; e_rdst[r] = {!m_val[a], 1'b0}; e_chk[r] = m_val[a];
            end
        end
        for (int ad = 0; ad < DEPTH; ad++) begin
            if (wcom[ad]) begin m_mem[ad] = wdat[ad]; m_val[ad] = 1'b1; end
        end
        if (hi >= 0) m_rr = (hi + 1) % NW;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr(); srst = 1'b1;
        step();
        n_vec++;
        if ({wrdone, wrcoll, rdvalid, rddata, rdstatus} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%h/%b want all zero",
                     wrdone, wrcoll, rdvalid, rddata, rdstatus);
        end
        srst = 1'b0;
        rd(0, 3);
        step();
        n_vec++;
        if (rdvalid[0] !== 1'b1 || rdstatus[1:0] !== 2'b10) begin
            n_err++;
            $display("FAIL reset_unwritten: got valid %b status %b want 1 10", rdvalid[0], rdstatus[1:0]);
        end
        clr();
    endtask

    task automatic test_distinct();
        clr(); wr(0, 2, 8'hA5); wr(1, 5, 8'h5A);
        step();
        n_vec++;
        if (wrdone !== 3'b011 || wrcoll !== 3'b000) begin
            n_err++;
            $display("FAIL distinct_wr: got done %b coll %b want 011 000", wrdone, wrcoll);
        end
        clr(); rd(0, 2); rd(1, 5);
        step();
        n_vec++;
        if (rdvalid !== 2'b11 || rddata !== 16'h5AA5 || rdstatus !== 4'b0000) begin
            n_err++;
            $display("FAIL distinct_rd: got v %b d %h s %b want 11 5aa5 0000", rdvalid, rddata, rdstatus);
        end
        clr();
    endtask

    task automatic test_rr();
        clr(); wr(0, 4, 8'h11); wr(1, 4, 8'h22);
        step();
        n_vec++;
        if (wrdone !== 3'b001 || wrcoll !== 3'b010) begin
            n_err++;
            $display("FAIL rr_first: got done %b coll %b want 001 010", wrdone, wrcoll);
        end
        step();
        n_vec++;
        if (wrdone !== 3'b010 || wrcoll !== 3'b001) begin
            n_err++;
            $display("FAIL rr_second: got done %b coll %b want 010 001", wrdone, wrcoll);
        end
        clr(); wr(0, 0, 8'h01); wr(1, 0, 8'h02); wr(2, 0, 8'h03); rd(0, 4);
        step();
        n_vec++;
        if (wrdone !== 3'b100 || wrcoll !== 3'b011) begin
            n_err++;
            $display("FAIL rr_third: got done %b coll %b want 100 011", wrdone, wrcoll);
        end
        n_vec++;
        if (rddata[7:0] !== 8'h22 || rdstatus[1:0] !== 2'b00) begin
            n_err++;
            $display("FAIL rr_final_rd: got %h/%b want 22/00", rddata[7:0], rdstatus[1:0]);
        end
        clr();
    endtask

    task automatic test_bypass();
        clr(); wr(0, 1, 8'h33);
        step();
        clr(); wr(0, 1, 8'h44); rd(0, 1);
        step();
        n_vec++;
        if (rddata[7:0] !== CollData || rdstatus[1:0] !== 2'b01) begin
            n_err++;
            $display("FAIL rd_wr_same_cycle: got %h/%b want %h/01", rddata[7:0], rdstatus[1:0], CollData);
        end
        clr(); rd(0, 1);
        step();
        n_vec++;
        if (rddata[7:0] !== 8'h44 || rdstatus[1:0] !== 2'b00) begin
            n_err++;
            $display("FAIL rd_after_coll: got %h/%b want 44/00", rddata[7:0], rdstatus[1:0]);
        end
        clr();
    endtask

    task automatic test_out_of_range();
        clr(); wr(0, 7, 8'hEE); wr(2, 6, 8'hDD);
        step();
        n_vec++;
        if (wrdone !== 3'b000 || wrcoll !== 3'b000) begin
            n_err++;
            $display("FAIL oor_wr: got done %b coll %b want 000 000", wrdone, wrcoll);
        end
        clr(); rd(1, 7);
        step();
        n_vec++;
        if (rdvalid !== 2'b10 || rddata[15:8] !== 8'h00 || rdstatus[3:2] !== 2'b10) begin
            n_err++;
            $display("FAIL oor_rd: got v %b d %h s %b want 10 00 10", rdvalid, rddata[15:8], rdstatus[3:2]);
        end
        clr();
    endtask

    task automatic test_srst_busy();
        clr(); wr(0, 3, 8'h01); wr(1, 3, 8'h02);
        step();
        clr(); srst = 1'b1;
        wr(0, 2, 8'h77); wr(1, 2, 8'h78); rd(0, 2); rd(1, 5);
        step();
        n_vec++;
        if ({wrdone, wrcoll, rdvalid, rddata, rdstatus} !== '0) begin
            n_err++;
            $display("FAIL srst_busy_pulses: got %b/%b/%b/%h/%b want all zero",
                     wrdone, wrcoll, rdvalid, rddata, rdstatus);
        end
        srst = 1'b0;
        clr(); rd(0, 2); rd(1, 5);
        step();
        n_vec++;
        if (rdstatus !== 4'b1010) begin
            n_err++;
            $display("FAIL srst_valid_clr: got %b want 1010", rdstatus);
        end
        clr(); wr(0, 0, 8'h10); wr(1, 0, 8'h20);
        step();
        n_vec++;
        if (wrdone !== 3'b001 || wrcoll !== 3'b010) begin
            n_err++;
            $display("FAIL srst_rr_ptr: got done %b coll %b want 001 010", wrdone, wrcoll);
        end
        clr();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clr();
            srst = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, 7), DW'($urandom));
            for (int r = 0; r < NR; r++)
                if ($urandom_range(0, 1) == 1) rd(r, $urandom_range(0, 7));
            step();
            n_vec++;
            if (wrdone !== e_wrdone || wrcoll !== e_wrcoll || rdvalid !== e_rdvalid) begin
                n_err++;
                $display("FAIL rand_pulses cyc %0d: got %b/%b/%b want %b/%b/%b", c,
                         wrdone, wrcoll, rdvalid, e_wrdone, e_wrcoll, e_rdvalid);
            end
            for (int r = 0; r < NR; r++) begin
                n_vec++;
                if (rdstatus[r*2 +: 2] !== e_rdst[r]) begin
                    n_err++;
                    $display("FAIL rand_status cyc %0d rd%0d: got %b want %b", c, r,
                             rdstatus[r*2 +: 2], e_rdst[r]);
                end
                if (e_chk[r]) begin
                    n_vec++;
                    if (rddata[r*DW +: DW] !== e_rddata[r]) begin
                        n_err++;
                        $display("FAIL rand_data cyc %0d rd%0d: got %h want %h", c, r,
                                 rddata[r*DW +: DW], e_rddata[r]);
                    end
                end
            end
        end
        srst = 1'b0;
        clr();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin m_mem[k] = '0; m_val[k] = 1'b0; end
        m_rr = 0;
        clr();
        srst = 1'b1;
        test_reset();
        test_distinct();
        test_rr();
        test_bypass();
        test_out_of_range();
        test_srst_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
